// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared constants, the write request type and the
// port-select encoding used by the register file write-port arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  // Register 15 does not exist; writes aimed at it are consumed silently.
  localparam logic [REG_ADDR_W-1:0] PC_REG = 4'hF;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // Which source owns the register file write port this cycle.
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_WB0    = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } wb_sel_e;

  // True when a destination names a real register that may be written.
  function automatic logic is_real_dest(input logic [REG_ADDR_W-1:0] dest);
    return dest != PC_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_req_fifo.sv
// wb_req_fifo: small circular queue holding late write-back requests.
// Besides the head it exports a per-entry valid bit and destination so the
// parent can compare decode-stage sources against every queued write.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_req_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_push,
  input  wb_req_t                          i_push_req,
  input  logic                             i_pop,
  output wb_req_t                          o_head,
  output logic [CNT_W-1:0]                 o_count,
  output logic [DEPTH-1:0]                 o_entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] o_entry_dest
);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;

  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [DEPTH-1:0] w_set_mask;
  logic [DEPTH-1:0] w_clr_mask;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  assign w_set_mask = DEPTH'(w_do_push) << r_wr_ptr;
  assign w_clr_mask = DEPTH'(w_do_pop) << r_rd_ptr;

  // Payload storage; contents of unused slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_req;
    end
  end

  // Pointers, occupancy and per-slot valid bits; reset drops everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_valid <= (r_valid | w_set_mask) & ~w_clr_mask;
    end
  end

  // Flatten the stored destinations for the parent's hazard compare.
  always_comb begin
    o_entry_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_dest[i] = r_mem[i].dest;
    end
  end

  assign o_head        = r_mem[r_rd_ptr];
  assign o_count       = r_count;
  assign o_entry_valid = r_valid;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the
// pipeline write-back stage (requester 0, always wins) and a late-result
// source (requester 1, valid/ready) whose results wait in a small FIFO and
// drain on idle write-back cycles. A starvation counter asks the pipeline
// for a bubble when the FIFO head waits too long, and a pending-destination
// compare flags decode-stage hazards against queued writes.
// Optional feature: define WB_ARB_BYPASS_EN to let requester 1 reach the
// port in the same cycle when the FIFO is empty and requester 0 is idle.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb0_en,
  input  logic [REG_ADDR_W-1:0]     wb0_dest,
  input  logic [DATA_W-1:0]         wb0_data,
  input  logic                      wb1_valid,
  input  logic [REG_ADDR_W-1:0]     wb1_dest,
  input  logic [DATA_W-1:0]         wb1_data,
  output logic                      wb1_ready,
  input  logic [REG_ADDR_W-1:0]     src1,
  input  logic [REG_ADDR_W-1:0]     src2,
  output logic                      pend_hazard,
  output logic                      stall_req,
  output logic                      writeBackEn,
  output logic [REG_ADDR_W-1:0]     destWB,
  output logic [DATA_W-1:0]         resultWB,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_sel_e                              w_sel;
  wb_req_t                              w_port_req;
  wb_req_t                              w_head;
  wb_req_t                              w_wb1_req;
  logic [CNT_W-1:0]                     w_count;
  logic [FIFO_DEPTH-1:0]                w_entry_valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_entry_dest;
  logic                                 w_fifo_empty;
  logic                                 w_bypass_cand;
  logic                                 w_push;
  logic                                 w_pop;
  logic                                 w_hazard;

  logic [7:0]                           r_starve_cnt;
  logic                                 r_stall;

  assign w_wb1_req    = '{dest: wb1_dest, data: wb1_data};
  assign w_fifo_empty = (w_count == '0);

`ifdef WB_ARB_BYPASS_EN
  assign w_bypass_cand = wb1_valid;
`else
  assign w_bypass_cand = 1'b0;
`endif

  // Ready reflects occupancy at the start of the cycle; no pass-through when full.
  assign wb1_ready = (w_count < CNT_W'(FIFO_DEPTH));

  // Port ownership: pipeline first, then the queued head, then the optional bypass.
  always_comb begin
    w_sel = SEL_NONE;
    if (rst) begin
      w_sel = SEL_NONE;
    end else if (wb0_en) begin
      w_sel = SEL_WB0;
    end else if (!w_fifo_empty) begin
      w_sel = SEL_FIFO;
    end else if (w_bypass_cand) begin
      w_sel = SEL_BYPASS;
    end
  end

  assign w_pop  = (w_sel == SEL_FIFO);
  assign w_push = wb1_valid && wb1_ready && !rst && (w_sel != SEL_BYPASS);

  // Drive the register file port from whichever source owns it this cycle.
  always_comb begin
    w_port_req = '0;
    case (w_sel)
      SEL_WB0:    w_port_req = '{dest: wb0_dest, data: wb0_data};
      SEL_FIFO:   w_port_req = w_head;
      SEL_BYPASS: w_port_req = w_wb1_req;
      default:    w_port_req = '0;
    endcase
  end

  // Writes to register 15 still consume their slot but never enable the port.
  assign writeBackEn = (w_sel != SEL_NONE) && is_real_dest(w_port_req.dest);
  assign destWB      = w_port_req.dest;
  assign resultWB    = w_port_req.data;

  wb_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_req   (w_wb1_req),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_entry_valid(w_entry_valid),
    .o_entry_dest (w_entry_dest)
  );

  assign fifo_count = w_count;

  // Conservative hazard: any queued real destination, including the one leaving now.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_valid[i] && is_real_dest(w_entry_dest[i]) &&
          ((w_entry_dest[i] == src1) || (w_entry_dest[i] == src2))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign pend_hazard = w_hazard && !rst;

  // Count how long the head has waited behind the pipeline; saturates at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_fifo_empty || w_pop) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != 8'hFF) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // Request a bubble once the head has starved long enough; drop it after the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= 1'b0;
    end else if (w_pop || w_fifo_empty) begin
      r_stall <= 1'b0;
    end else if (r_starve_cnt >= 8'(STARVE_LIMIT)) begin
      r_stall <= 1'b1;
    end
  end

  assign stall_req = r_stall;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter.
// Expected register file writes are queued with the cycle they must appear in
// and are matched against the write port on every falling edge.
// Build with WB_ARB_BYPASS_EN defined to exercise the bypass variant.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb0_en;
  logic [3:0]  wb0_dest;
  logic [31:0] wb0_data;
  logic        wb1_valid;
  logic [3:0]  wb1_dest;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        pend_hazard;
  logic        stall_req;
  logic        writeBackEn;
  logic [3:0]  destWB;
  logic [31:0] resultWB;
  logic [2:0]  fifo_count;

  typedef struct {
    int          cyc;
    logic [3:0]  dest;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   nChecks = 0;
  int   nPass   = 0;
  int   nFail   = 0;

  regfile_wb_arbiter #(
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb0_en     (wb0_en),
    .wb0_dest   (wb0_dest),
    .wb0_data   (wb0_data),
    .wb1_valid  (wb1_valid),
    .wb1_dest   (wb1_dest),
    .wb1_data   (wb1_data),
    .wb1_ready  (wb1_ready),
    .src1       (src1),
    .src2       (src2),
    .pend_hazard(pend_hazard),
    .stall_req  (stall_req),
    .writeBackEn(writeBackEn),
    .destWB     (destWB),
    .resultWB   (resultWB),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic e0, input logic [3:0] d0, input logic [31:0] x0,
                               input logic v1, input logic [3:0] d1, input logic [31:0] x1);
    wb0_en    = e0;
    wb0_dest  = d0;
    wb0_data  = x0;
    wb1_valid = v1;
    wb1_dest  = d1;
    wb1_data  = x1;
    #1;
  endtask

  task automatic expectWrite(input int off, input logic [3:0] d, input logic [31:0] x);
    exp_t e;
    e.cyc  = cyc + off;
    e.dest = d;
    e.data = x;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (writeBackEn) begin
      if (sb.size() == 0) begin
        check("wb_unexpected_en", 32'(writeBackEn), 32'(0));
      end else begin
        e = sb.pop_front();
        check("wb_cycle", cyc, e.cyc);
        check("wb_dest", 32'(destWB), 32'(e.dest));
        check("wb_data", resultWB, e.data);
      end
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      check("wb_missing_en", 32'(writeBackEn), 32'(1));
      e = sb.pop_front();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst  = 1'b1;
    src1 = 4'd0;
    src2 = 4'd0;
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    tick();

    // Reset values
    check("rst_wbEn", 32'(writeBackEn), 32'(0));
    check("rst_destWB", 32'(destWB), 32'(0));
    check("rst_resultWB", resultWB, 32'(0));
    check("rst_wb1_ready", 32'(wb1_ready), 32'(1));
    check("rst_hazard", 32'(pend_hazard), 32'(0));
    check("rst_stall", 32'(stall_req), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    rst = 1'b0;
    tick();

    // Simultaneous wb0 and wb1 with empty FIFO
    applyStimulus(1'b1, 4'd3, 32'hAA, 1'b1, 4'd5, 32'hBB);
    expectWrite(0, 4'd3, 32'hAA);
    expectWrite(1, 4'd5, 32'hBB);
    check("t1_ready", 32'(wb1_ready), 32'(1));
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    check("t1_count_q", 32'(fifo_count), 32'(1));
    tick();
    check("t1_count_e", 32'(fifo_count), 32'(0));

    // Fill with wb0 busy (one wb0 write to r15), then reject, then drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, (i == 2) ? 4'hF : 4'd1, 32'h100 + 32'(i),
                    1'b1, (i == 3) ? 4'd8 : 4'(4 + i), 32'hC0 + 32'(i));
      if (i != 2) expectWrite(0, 4'd1, 32'h100 + 32'(i));
      tick();
    end
    check("t2_full_count", 32'(fifo_count), 32'(4));
    check("t2_full_ready", 32'(wb1_ready), 32'(0));
    applyStimulus(1'b1, 4'd1, 32'h104, 1'b1, 4'd9, 32'hDEAD);
    expectWrite(0, 4'd1, 32'h104);
    tick();
    check("t2_no_fifth", 32'(fifo_count), 32'(4));
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    expectWrite(0, 4'd4, 32'hC0);
    expectWrite(1, 4'd5, 32'hC1);
    expectWrite(2, 4'd6, 32'hC2);
    expectWrite(3, 4'd8, 32'hC3);
    for (int i = 0; i < 4; i++) tick();
    check("t2_drained", 32'(fifo_count), 32'(0));
    check("t2_stall", 32'(stall_req), 32'(0));

    // Pending-destination hazard, dest 15 never matches and is never written
    src1 = 4'd7;
    applyStimulus(1'b1, 4'd1, 32'h11, 1'b1, 4'd7, 32'h77);
    expectWrite(0, 4'd1, 32'h11);
    check("t3_haz_before", 32'(pend_hazard), 32'(0));
    tick();
    src2 = 4'hF;
    applyStimulus(1'b1, 4'd1, 32'h12, 1'b1, 4'hF, 32'hFF);
    expectWrite(0, 4'd1, 32'h12);
    check("t3_haz_queued", 32'(pend_hazard), 32'(1));
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    expectWrite(0, 4'd7, 32'h77);
    check("t3_haz_deq", 32'(pend_hazard), 32'(1));
    tick();
    check("t3_haz_r15", 32'(pend_hazard), 32'(0));
    check("t3_r15_noen", 32'(writeBackEn), 32'(0));
    check("t3_count_r15", 32'(fifo_count), 32'(1));
    tick();
    check("t3_count_e", 32'(fifo_count), 32'(0));
    src1 = 4'd0;
    src2 = 4'd0;

    // Starvation: wb0 held busy, stall rises 9 cycles after enqueue
    applyStimulus(1'b1, 4'd2, 32'h200, 1'b1, 4'd10, 32'hA0A0);
    expectWrite(0, 4'd2, 32'h200);
    tick();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 4'd2, 32'h200 + 32'(i), 1'b0, 4'd0, 32'd0);
      expectWrite(0, 4'd2, 32'h200 + 32'(i));
      if (i == 1 || i == 9) check("t4_stall_low", 32'(stall_req), 32'(0));
      tick();
    end
    applyStimulus(1'b1, 4'd2, 32'h20A, 1'b0, 4'd0, 32'd0);
    expectWrite(0, 4'd2, 32'h20A);
    check("t4_stall_high", 32'(stall_req), 32'(1));
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    expectWrite(0, 4'd10, 32'hA0A0);
    check("t4_stall_hold", 32'(stall_req), 32'(1));
    tick();
    check("t4_stall_fall", 32'(stall_req), 32'(0));
    check("t4_count", 32'(fifo_count), 32'(0));

    // Reset with three entries queued drops them
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd1, 32'h300 + 32'(i), 1'b1, 4'(11 + i), 32'hE0 + 32'(i));
      expectWrite(0, 4'd1, 32'h300 + 32'(i));
      tick();
    end
    check("t5_count_pre", 32'(fifo_count), 32'(3));
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    check("t5_rst_noen", 32'(writeBackEn), 32'(0));
    tick();
    rst  = 1'b0;
    src1 = 4'd11;
    #1;
    check("t5_count", 32'(fifo_count), 32'(0));
    check("t5_ready", 32'(wb1_ready), 32'(1));
    check("t5_hazard", 32'(pend_hazard), 32'(0));
    check("t5_stall", 32'(stall_req), 32'(0));
    for (int i = 0; i < 3; i++) tick();
    src1 = 4'd2;

    // Lone wb1 request with FIFO empty and wb0 idle
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h1234);
`ifdef WB_ARB_BYPASS_EN
    expectWrite(0, 4'd2, 32'h1234);
    check("t6_byp_en", 32'(writeBackEn), 32'(1));
    check("t6_byp_dest", 32'(destWB), 32'(2));
    check("t6_byp_data", resultWB, 32'h1234);
    check("t6_byp_haz", 32'(pend_hazard), 32'(0));
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    check("t6_byp_count", 32'(fifo_count), 32'(0));
    tick();
`else
    expectWrite(1, 4'd2, 32'h1234);
    check("t6_lat_noen", 32'(writeBackEn), 32'(0));
    check("t6_lat_haz0", 32'(pend_hazard), 32'(0));
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    check("t6_lat_count", 32'(fifo_count), 32'(1));
    check("t6_lat_haz1", 32'(pend_hazard), 32'(1));
    tick();
    check("t6_lat_empty", 32'(fifo_count), 32'(0));
`endif
    src1 = 4'd0;
    tick();
    tick();
    check("sb_empty_at_end", sb.size(), 32'(0));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
